// File: rtl/pzvbus_arbiter_pkg.sv
// Shared types for the pzvbus grant arbiter.
// Selects the arbitration policy used by pzvbus_grant_arbiter.
package pzvbus_arbiter_pkg;

  typedef enum logic {
    PZVBUS_ARB_FIXED       = 1'b0,
    PZVBUS_ARB_ROUND_ROBIN = 1'b1
  } pzvbus_arb_mode;

endpackage

// File: rtl/pzvbus_arbiter_pick.sv
// Combinational one-hot picker: lowest set bit of (req & mask), falling back
// to the lowest set bit of req when nothing survives the mask.
module pzvbus_arbiter_pick #(
  parameter int unsigned SLAVES = 2
) (
  input  logic [SLAVES-1:0] i_req,
  input  logic [SLAVES-1:0] i_mask,
  output logic [SLAVES-1:0] o_grant
);

  localparam logic [SLAVES-1:0] ONE = SLAVES'(1);

  logic [SLAVES-1:0] masked;
  logic [SLAVES-1:0] sel;

  assign masked  = i_req & i_mask;
  assign sel     = (masked != '0) ? masked : i_req;
  // Two's-complement isolate of the lowest set bit.
  assign o_grant = sel & (~sel + ONE);

endmodule

// File: rtl/pzvbus_grant_arbiter.sv
// Grant arbiter feeding the pzvbus one-hot mux select: grants combinationally
// when free, then holds the grant until the transfer (or packet) completes.
module pzvbus_grant_arbiter
  import pzvbus_arbiter_pkg::*;
#(
  parameter int unsigned    SLAVES      = 2,
  parameter pzvbus_arb_mode MODE        = PZVBUS_ARB_FIXED,
  parameter bit             PACKET_LOCK = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [SLAVES-1:0] i_request,
  input  logic              i_ack,
  input  logic              i_last,
  output logic [SLAVES-1:0] o_grant,
  output logic              o_busy
);

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [SLAVES-1:0] ALL_ONES = '1;
  localparam logic [SLAVES-1:0] ONE      = SLAVES'(1);

  state_e            state_q, state_d;
  logic [SLAVES-1:0] grant_q, grant_d;
  logic [SLAVES-1:0] rr_mask_q, rr_mask_d;
  logic [SLAVES-1:0] pick_mask, pick_grant, gnt, thermo;
  logic              rel;

  assign rel       = i_ack & (!PACKET_LOCK | i_last);
  assign pick_mask = (MODE == PZVBUS_ARB_ROUND_ROBIN) ? rr_mask_q : ALL_ONES;

  pzvbus_arbiter_pick #(
    .SLAVES (SLAVES)
  ) u_pick (
    .i_req   (i_request),
    .i_mask  (pick_mask),
    .o_grant (pick_grant)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_mask_d = rr_mask_q;
    gnt       = '0;
    thermo    = '0;
    if (state_q == ST_FREE) begin
      gnt = pick_grant;
      if ((pick_grant != '0) && !rel) begin
        state_d = ST_LOCKED;
        grant_d = pick_grant;
      end
    end else begin
      gnt = grant_q;
      if (rel) begin
        state_d = ST_FREE;
        grant_d = '0;
      end
    end
    // Pointer moves just past the completed grant; granting the top index wraps.
    if ((MODE == PZVBUS_ARB_ROUND_ROBIN) && rel && (gnt != '0)) begin
      thermo    = ~((gnt << 1) - ONE);
      rr_mask_d = (thermo == '0) ? ALL_ONES : thermo;
    end
  end

  assign o_grant = i_rst ? '0 : gnt;
  assign o_busy  = (state_q == ST_LOCKED) && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_FREE;
      grant_q   <= '0;
      rr_mask_q <= ALL_ONES;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_mask_q <= rr_mask_d;
    end
  end

  // Grant of a locked, uncompleted cycle must reappear unchanged next cycle.
  logic              hold_chk_q;
  logic [SLAVES-1:0] prev_grant_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_chk_q   <= 1'b0;
      prev_grant_q <= '0;
    end else begin
      assert ($onehot0(o_grant));
      if (hold_chk_q) begin
        assert (o_grant == prev_grant_q);
      end
      hold_chk_q   <= (state_q == ST_LOCKED) && !rel;
      prev_grant_q <= o_grant;
    end
  end

  cover property (@(posedge i_clk) !i_rst && i_ack && (o_grant == '0));
  cover property (@(posedge i_clk) !i_rst && (state_q == ST_LOCKED) && ((i_request & grant_q) == '0));

endmodule

// File: tb/tb_pzvbus_grant_arbiter.sv
// Directed bench for pzvbus_grant_arbiter: fixed, round-robin, packet-lock
// and two-slave round-robin instances exercised one scenario at a time.
module tb_pzvbus_grant_arbiter;
  import pzvbus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ack = 1'b0;
  logic       last = 1'b0;
  logic [3:0] req_fix = '0, req_rr = '0, req_pkt = '0;
  logic [1:0] req_r2 = '0;
  logic [3:0] g_fix, g_rr, g_pkt;
  logic [1:0] g_r2;
  logic       b_fix, b_rr, b_pkt, b_r2;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  pzvbus_grant_arbiter #(.SLAVES(4), .MODE(PZVBUS_ARB_FIXED), .PACKET_LOCK(1'b0)) u_fix (
    .i_clk(clk), .i_rst(rst), .i_request(req_fix), .i_ack(ack), .i_last(last),
    .o_grant(g_fix), .o_busy(b_fix));
  pzvbus_grant_arbiter #(.SLAVES(4), .MODE(PZVBUS_ARB_ROUND_ROBIN), .PACKET_LOCK(1'b0)) u_rr (
    .i_clk(clk), .i_rst(rst), .i_request(req_rr), .i_ack(ack), .i_last(last),
    .o_grant(g_rr), .o_busy(b_rr));
  pzvbus_grant_arbiter #(.SLAVES(4), .MODE(PZVBUS_ARB_FIXED), .PACKET_LOCK(1'b1)) u_pkt (
    .i_clk(clk), .i_rst(rst), .i_request(req_pkt), .i_ack(ack), .i_last(last),
    .o_grant(g_pkt), .o_busy(b_pkt));
  pzvbus_grant_arbiter #(.SLAVES(2), .MODE(PZVBUS_ARB_ROUND_ROBIN), .PACKET_LOCK(1'b0)) u_r2 (
    .i_clk(clk), .i_rst(rst), .i_request(req_r2), .i_ack(ack), .i_last(last),
    .o_grant(g_r2), .o_busy(b_r2));

  // Fixed priority, lock then held against a higher-priority arrival.
  localparam logic [3:0] LH_REQ [0:6] = '{4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b0001};
  localparam logic       LH_ACK [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [3:0] LH_GNT [0:6] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
  localparam logic       LH_BSY [0:6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  // Round-robin rotation with all requests held.
  localparam logic [3:0] RR_GNT [0:4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  // Packet lock: 4-beat packet on slave 2, slave 0 arrives mid-packet.
  localparam logic [3:0] PK_REQ  [0:4] = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
  localparam logic       PK_LAST [0:4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [3:0] PK_GNT  [0:4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
  localparam logic       PK_BSY  [0:4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  // Reset mid-lock on the round-robin instance (pointer enters at 1110).
  localparam logic [3:0] RM_REQ [0:5] = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0010};
  localparam logic       RM_RST [0:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic       RM_ACK [0:5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [3:0] RM_GNT [0:5] = '{4'b0010, 4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0010};
  localparam logic       RM_BSY [0:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  // Ack with nothing granted must not move the pointer (enters at 1100).
  localparam logic [3:0] AI_REQ [0:3] = '{4'b0000, 4'b0000, 4'b0110, 4'b0110};
  localparam logic       AI_ACK [0:3] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [3:0] AI_GNT [0:3] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100};
  localparam logic       AI_BSY [0:3] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // Two-slave round robin including wrap from index 1.
  localparam logic [1:0] R2_REQ [0:6] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11};
  localparam logic       R2_ACK [0:6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [1:0] R2_GNT [0:6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
  localparam logic       R2_BSY [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic idle_cycle();
    @(negedge clk);
    req_fix = '0; req_rr = '0; req_pkt = '0; req_r2 = '0;
    ack = 1'b0; last = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_fix = 4'b1111; req_rr = 4'b1111; ack = 1'b1; last = 1'b1;
    #1;
    $display("reset: grant_fix=%b busy_fix=%b grant_rr=%b", g_fix, b_fix, g_rr);
    if (g_fix !== 4'b0000) begin $display("FAIL reset_grant_fix: got %b want 0000", g_fix); n_fail++; end
    n_checks++;
    if (b_fix !== 1'b0) begin $display("FAIL reset_busy_fix: got %b want 0", b_fix); n_fail++; end
    n_checks++;
    if (g_rr !== 4'b0000) begin $display("FAIL reset_grant_rr: got %b want 0000", g_rr); n_fail++; end
    n_checks++;
    idle_cycle();
  endtask

  task automatic test_single_cycle();
    @(negedge clk);
    req_fix = 4'b1010; ack = 1'b1; last = 1'b1;
    #1;
    $display("single: req=%b grant=%b busy=%b", req_fix, g_fix, b_fix);
    if (g_fix !== 4'b0010) begin $display("FAIL single_grant: got %b want 0010", g_fix); n_fail++; end
    n_checks++;
    if (b_fix !== 1'b0) begin $display("FAIL single_busy: got %b want 0", b_fix); n_fail++; end
    n_checks++;
    @(negedge clk);
    req_fix = 4'b1111; ack = 1'b1; last = 1'b1;
    #1;
    $display("single: req=%b grant=%b busy=%b", req_fix, g_fix, b_fix);
    if (b_fix !== 1'b0) begin $display("FAIL single_stays_free: got %b want 0", b_fix); n_fail++; end
    n_checks++;
    if (g_fix !== 4'b0001) begin $display("FAIL all_req_grant: got %b want 0001", g_fix); n_fail++; end
    n_checks++;
    idle_cycle();
  endtask

  task automatic test_lock_hold();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_fix = LH_REQ[i]; ack = LH_ACK[i]; last = 1'b0;
      #1;
      $display("lock_hold %0d: req=%b ack=%b grant=%b busy=%b", i, req_fix, ack, g_fix, b_fix);
      if (g_fix !== LH_GNT[i]) begin $display("FAIL lock_hold_grant[%0d]: got %b want %b", i, g_fix, LH_GNT[i]); n_fail++; end
      n_checks++;
      if (b_fix !== LH_BSY[i]) begin $display("FAIL lock_hold_busy[%0d]: got %b want %b", i, b_fix, LH_BSY[i]); n_fail++; end
      n_checks++;
    end
    idle_cycle();
  endtask

  task automatic test_rr_rotation();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_rr = 4'b1111; ack = 1'b1; last = 1'b1;
      #1;
      $display("rr %0d: grant=%b busy=%b", i, g_rr, b_rr);
      if (g_rr !== RR_GNT[i]) begin $display("FAIL rr_grant[%0d]: got %b want %b", i, g_rr, RR_GNT[i]); n_fail++; end
      n_checks++;
      if (b_rr !== 1'b0) begin $display("FAIL rr_busy[%0d]: got %b want 0", i, b_rr); n_fail++; end
      n_checks++;
    end
    idle_cycle();
  endtask

  task automatic test_packet_lock();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_pkt = PK_REQ[i]; ack = 1'b1; last = PK_LAST[i];
      #1;
      $display("packet %0d: req=%b last=%b grant=%b busy=%b", i, req_pkt, last, g_pkt, b_pkt);
      if (g_pkt !== PK_GNT[i]) begin $display("FAIL packet_grant[%0d]: got %b want %b", i, g_pkt, PK_GNT[i]); n_fail++; end
      n_checks++;
      if (b_pkt !== PK_BSY[i]) begin $display("FAIL packet_busy[%0d]: got %b want %b", i, b_pkt, PK_BSY[i]); n_fail++; end
      n_checks++;
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid_lock();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_rr = RM_REQ[i]; rst = RM_RST[i]; ack = RM_ACK[i]; last = 1'b1;
      #1;
      $display("reset_mid %0d: rst=%b req=%b grant=%b busy=%b", i, rst, req_rr, g_rr, b_rr);
      if (g_rr !== RM_GNT[i]) begin $display("FAIL reset_mid_grant[%0d]: got %b want %b", i, g_rr, RM_GNT[i]); n_fail++; end
      n_checks++;
      if (b_rr !== RM_BSY[i]) begin $display("FAIL reset_mid_busy[%0d]: got %b want %b", i, b_rr, RM_BSY[i]); n_fail++; end
      n_checks++;
    end
    idle_cycle();
  endtask

  task automatic test_ack_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_rr = AI_REQ[i]; ack = AI_ACK[i]; last = 1'b1;
      #1;
      $display("ack_idle %0d: req=%b ack=%b grant=%b busy=%b", i, req_rr, ack, g_rr, b_rr);
      if (g_rr !== AI_GNT[i]) begin $display("FAIL ack_idle_grant[%0d]: got %b want %b", i, g_rr, AI_GNT[i]); n_fail++; end
      n_checks++;
      if (b_rr !== AI_BSY[i]) begin $display("FAIL ack_idle_busy[%0d]: got %b want %b", i, b_rr, AI_BSY[i]); n_fail++; end
      n_checks++;
    end
    idle_cycle();
  endtask

  task automatic test_two_slave_rr();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_r2 = R2_REQ[i]; ack = R2_ACK[i]; last = 1'b1;
      #1;
      $display("rr2 %0d: req=%b ack=%b grant=%b busy=%b", i, req_r2, ack, g_r2, b_r2);
      if (g_r2 !== R2_GNT[i]) begin $display("FAIL rr2_grant[%0d]: got %b want %b", i, g_r2, R2_GNT[i]); n_fail++; end
      n_checks++;
      if (b_r2 !== R2_BSY[i]) begin $display("FAIL rr2_busy[%0d]: got %b want %b", i, b_r2, R2_BSY[i]); n_fail++; end
      n_checks++;
    end
    idle_cycle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_single_cycle();
    test_lock_hold();
    test_rr_rotation();
    test_packet_lock();
    test_reset_mid_lock();
    test_ack_idle();
    test_two_slave_rr();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
